ps2_key_matrix: RTL and testbench
=================================

Name: ps2_key_matrix

Overview:
- Parametrised PS/2-to-keyboard-matrix emulator; successor to the hard-wired key/joystick mapping in the console top level.
- Holds the pressed state of a ROWS x COLS matrix fed by the hps_io ps2_key toggle interface, plus a set of toggling lock keys.
- Merges NUM_JOY joystick ports into fixed matrix positions.
- Answers the console's active-low row strobes with active-low column returns; enforces a minimum press visibility so short keystrokes are not missed between console scans.

Parameters:
- ROWS, 8: matrix rows (row strobes from the console).
- COLS, 8: matrix columns (key return lines).
- NUM_JOY, 2: joystick ports merged into the matrix, 5 bits each.
- NUM_LOCK, 1: toggling lock keys (alpha lock); each has its own strobe input.
- HOLD_TICKS, 2: minimum number of tick_i pulses a pressed key stays visible; range 0..3.

Ports:
- clk_i, in, 1: system clock.
- reset_n_i, in, 1: asynchronous, active-low reset.
- ps2_key_i, in, 11: bit 10 is a toggle per event, bit 9 is pressed, bit 8 is extended, bits 7:0 are the scancode.
- tick_i, in, 1: one-cycle hold-time pulse (typically per video frame).
- release_all_i, in, 1: synchronous clear of all non-lock keys.
- joy_i, in, NUM_JOY*5: per port {fire, up, down, left, right}, active-high.
- row_sel_n_i, in, ROWS: active-low row strobes; several may be low at once.
- lock_sel_n_i, in, NUM_LOCK: active-low lock strobes.
- col_n_o, out, COLS: active-low column returns, registered.
- lock_o, out, NUM_LOCK: current lock toggle state.

Behaviour:
- Reset: all key bits, hold counters, pending bits and lock_o go to 0. col_n_o goes to all-ones. The internal toggle copy is loaded from 0.
- Event detect, cycle N: ps2_key_i[10] differs from its registered copy. ps2_key_i is sampled in that cycle.
- Lookup, cycle N+1: the registered keymap gives {valid, is_lock, lock_idx, row, col}. Unmapped codes are ignored.
- Update, cycle N+2:
  - Press on a normal key: key bit set to 1, counter loaded with HOLD_TICKS, pending cleared.
  - Release on a normal key: if counter is 0, key bit cleared in this cycle; otherwise pending is set to 1.
  - Lock key: press inverts lock_o[lock_idx]; release is ignored.
- Hold counter, every tick_i: all nonzero counters decrement by 1.
- Deferred release: any key with pending=1 and counter=0 is cleared on the following clk_i, and pending is cleared with it.
- Same key, same cycle: the event is applied first, then the tick. Release with counter=1 plus tick gives pending=1 and counter=0, so the key clears one cycle later.
- Re-press while pending: pending is cleared and the counter reloads. The key never drops.
- HOLD_TICKS=0: every release clears immediately.
- release_all_i: key bits, counters and pending bits cleared next cycle; lock_o is unchanged. If a ps2 update lands in the same cycle, release_all_i takes priority.
- Joystick: joy bits are OR'd into (row, col) positions from package table JOY_POS. They bypass hold logic.
- Matrix read: col_n_o[c] is registered as ~(OR over rows r with row_sel_n_i[r]=0 of (key[r][c] | joy_at[r][c]) | OR over locks l with lock_sel_n_i[l]=0 and LOCK_COL[l]=c of lock_o[l]). Latency is 1 cycle from a row_sel_n_i change.
- Row strobes all high: col_n_o is all-ones.
- A key pressed for under one tick stays visible for HOLD_TICKS ticks after its press.
- Reset mid-operation: all state is lost immediately and the asynchronous reset result is presented. Events still in the pipeline are discarded.

Optional Feature:
- KBD_MIN_HOLD_EN
- Defined: hold counters, pending bits and tick_i behave as described above.
- Undefined: no counters or pending bits are instantiated; tick_i is ignored; releases clear the key bit at N+2; HOLD_TICKS is unused.

Decomposition:
- Package ps2_key_matrix_pkg:
  - typedef key_pos_t {row[2:0], col[2:0]}.
  - typedef keymap_entry_t {valid, is_lock, lock_idx, key_pos_t}.
  - Constants JOY_POS[NUM_JOY][5], LOCK_COL[NUM_LOCK], HOLD_W=2.
- Sub-module ps2_keymap_rom: registered 9-bit {extended, scancode} to keymap_entry_t lookup, holding the TI layout (e.g. 0x1C maps to a, 0x58 maps to lock 0).
- The main module holds the state array, hold logic and matrix read.

Test Plan:
- Press 0x1C ('a', mapped to row 5, col 2), drive row_sel_n_i=8'hDF: col_n_o=8'hFB at N+3 and later; all other rows read 8'hFF.
- Press then release 0x1C 4 cycles apart, HOLD_TICKS=2, no tick: still visible. First tick: still visible. Second tick: col_n_o returns to 8'hFF one cycle after pending clear (macro defined). Without the macro: 8'hFF at release N+2.
- Press/release/press 0x58: lock_o goes 0, then 1, then stays 1 on release, then 0. With lock_sel_n_i=0 the LOCK_COL bit goes low only while lock_o=1.
- joy_i port 0 fire=1 with row strobe at the JOY_POS row low: the matching column goes low next cycle. release_all_i does not clear it.
- Same key: release event and tick_i in the same cycle with counter=1: key visible one more cycle, then cleared. Re-press during pending: never drops.
- Assert reset_n_i=0 with keys held and lock_o=1: col_n_o=all-ones and lock_o=0 immediately. An event toggled during reset is not applied after release.

Source files
------------

// File: rtl/ps2_key_matrix_pkg.sv
// Shared types and fixed layout tables for the PS/2-to-keyboard-matrix emulator.
package ps2_key_matrix_pkg;

  localparam int HOLD_W     = 2;
  localparam int JOY_PORTS  = 2;
  localparam int LOCK_KEYS  = 1;
  localparam int LOCK_IDX_W = 1;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_lock;
    logic [LOCK_IDX_W-1:0] lock_idx;
    key_pos_t              pos;
  } keymap_entry_t;

  // Per port, index = joystick bit: 0 right, 1 left, 2 down, 3 up, 4 fire.
  localparam key_pos_t JOY_POS [JOY_PORTS][5] = '{
    '{'{3'd6, 3'd2}, '{3'd6, 3'd1}, '{3'd6, 3'd3}, '{3'd6, 3'd4}, '{3'd6, 3'd0}},
    '{'{3'd7, 3'd2}, '{3'd7, 3'd1}, '{3'd7, 3'd3}, '{3'd7, 3'd4}, '{3'd7, 3'd0}}
  };

  localparam logic [2:0] LOCK_COL [LOCK_KEYS] = '{3'd4};

  function automatic keymap_entry_t key_at(input int r, input int c);
    keymap_entry_t e;
    e         = '0;
    e.valid   = 1'b1;
    e.pos.row = 3'(r);
    e.pos.col = 3'(c);
    return e;
  endfunction

  function automatic keymap_entry_t lock_key(input int idx);
    keymap_entry_t e;
    e          = '0;
    e.valid    = 1'b1;
    e.is_lock  = 1'b1;
    e.lock_idx = LOCK_IDX_W'(idx);
    return e;
  endfunction

endpackage

// File: rtl/ps2_keymap_rom.sv
// Registered {extended, scancode} to matrix position lookup holding the TI console layout.
module ps2_keymap_rom
  import ps2_key_matrix_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic [8:0]    code_i,
  output keymap_entry_t entry_o
);

  keymap_entry_t entry_d;

  always_comb begin
    entry_d = '0;
    case (code_i)
      9'h01C:  entry_d = key_at(5, 2);  // a
      9'h01B:  entry_d = key_at(1, 2);  // s
      9'h023:  entry_d = key_at(2, 2);  // d
      9'h02B:  entry_d = key_at(3, 2);  // f
      9'h015:  entry_d = key_at(5, 3);  // q
      9'h01D:  entry_d = key_at(1, 3);  // w
      9'h024:  entry_d = key_at(2, 3);  // e
      9'h02D:  entry_d = key_at(3, 3);  // r
      9'h016:  entry_d = key_at(5, 4);  // 1
      9'h01E:  entry_d = key_at(1, 4);  // 2
      9'h029:  entry_d = key_at(1, 0);  // space
      9'h05A:  entry_d = key_at(2, 0);  // enter
      9'h012:  entry_d = key_at(4, 0);  // shift
      9'h014:  entry_d = key_at(0, 1);  // ctrl
      9'h111:  entry_d = key_at(3, 0);  // right alt as fctn
      9'h058:  entry_d = lock_key(0);   // caps lock as alpha lock
      default: entry_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) entry_o <= '0;
    else            entry_o <= entry_d;
  end

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 key events to TI-style scanned key matrix with joystick merge and lock keys.
// Build option: define KBD_MIN_HOLD_EN for minimum press visibility (hold counters).
module ps2_key_matrix
  import ps2_key_matrix_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int NUM_JOY    = 2,
  parameter int NUM_LOCK   = 1,
  parameter int HOLD_TICKS = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [10:0]          ps2_key_i,
  input  logic                 tick_i,
  input  logic                 release_all_i,
  input  logic [NUM_JOY*5-1:0] joy_i,
  input  logic [ROWS-1:0]      row_sel_n_i,
  input  logic [NUM_LOCK-1:0]  lock_sel_n_i,
  output logic [COLS-1:0]      col_n_o,
  output logic [NUM_LOCK-1:0]  lock_o
);

  // ps2_key_i is a toggle interface: each flip of bit 10 announces one event,
  // bits 9:0 are valid in that cycle and there is no backpressure. The first
  // cycle after reset only adopts the toggle level so stale flips are dropped.
  logic          tog_q, armed_q, evt_q, pressed_q, evt_now;
  keymap_entry_t ent_q;
  logic          upd_key, upd_lock;

  assign evt_now = armed_q && (ps2_key_i[10] != tog_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tog_q     <= 1'b0;
      armed_q   <= 1'b0;
      evt_q     <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      tog_q     <= ps2_key_i[10];
      armed_q   <= 1'b1;
      evt_q     <= evt_now;
      pressed_q <= ps2_key_i[9];
    end
  end

  ps2_keymap_rom u_rom (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .code_i    (ps2_key_i[8:0]),
    .entry_o   (ent_q)
  );

  assign upd_key  = evt_q && ent_q.valid && !ent_q.is_lock;
  assign upd_lock = evt_q && ent_q.valid && ent_q.is_lock && pressed_q;

  logic [ROWS-1:0][COLS-1:0] key_q, key_d;
  logic [NUM_LOCK-1:0]       lock_d;

`ifdef KBD_MIN_HOLD_EN
  logic [ROWS-1:0][COLS-1:0][HOLD_W-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0][COLS-1:0]             pend_q, pend_d;

  // Per key: deferred release, then the event, then the tick decrement.
  always_comb begin
    key_d  = key_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (pend_q[r][c] && cnt_q[r][c] == '0) begin
          key_d[r][c]  = 1'b0;
          pend_d[r][c] = 1'b0;
        end
        if (upd_key && int'(ent_q.pos.row) == r && int'(ent_q.pos.col) == c) begin
          if (pressed_q) begin
            key_d[r][c]  = 1'b1;
            cnt_d[r][c]  = HOLD_W'(HOLD_TICKS);
            pend_d[r][c] = 1'b0;
          end else if (cnt_q[r][c] == '0) begin
            key_d[r][c]  = 1'b0;
          end else begin
            pend_d[r][c] = 1'b1;
          end
        end
        if (tick_i && cnt_d[r][c] != '0) cnt_d[r][c] = cnt_d[r][c] - HOLD_W'(1);
      end
    end
    if (release_all_i) begin
      key_d  = '0;
      cnt_d  = '0;
      pend_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end
`else
  always_comb begin
    key_d = key_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (upd_key && int'(ent_q.pos.row) == r && int'(ent_q.pos.col) == c)
          key_d[r][c] = pressed_q;
      end
    end
    if (release_all_i) key_d = '0;
  end

  logic unused_hold_cfg;
  assign unused_hold_cfg = tick_i ^ (HOLD_TICKS != 0);
`endif

  always_comb begin
    lock_d = lock_o;
    for (int l = 0; l < NUM_LOCK; l++) begin
      if (upd_lock && int'(ent_q.lock_idx) == l) lock_d[l] = ~lock_o[l];
    end
  end

  logic [ROWS-1:0][COLS-1:0] joy_at;
  logic [COLS-1:0]           col_hit;

  always_comb begin
    joy_at = '0;
    for (int p = 0; p < NUM_JOY; p++) begin
      for (int b = 0; b < 5; b++) begin
        if (joy_i[p*5+b]) joy_at[JOY_POS[p][b].row][JOY_POS[p][b].col] = 1'b1;
      end
    end
  end

  always_comb begin
    col_hit = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_sel_n_i[r]) col_hit = col_hit | key_q[r] | joy_at[r];
    end
    for (int l = 0; l < NUM_LOCK; l++) begin
      if (!lock_sel_n_i[l] && lock_o[l]) col_hit[LOCK_COL[l]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      key_q   <= '0;
      lock_o  <= '0;
      col_n_o <= '1;
    end else begin
      key_q   <= key_d;
      lock_o  <= lock_d;
      col_n_o <= ~col_hit;
    end
  end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Bench for ps2_key_matrix: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_ps2_key_matrix;

  localparam int ROWS       = 8;
  localparam int COLS       = 8;
  localparam int NUM_JOY    = 2;
  localparam int NUM_LOCK   = 1;
  localparam int HOLD_TICKS = 2;
  localparam int LOCK_COL_B = 4;
  localparam int JCOL [5]   = '{2, 1, 3, 4, 0};

  logic                 clk_i = 1'b0;
  logic                 reset_n_i;
  logic [10:0]          ps2_key_i;
  logic                 tick_i;
  logic                 release_all_i;
  logic [NUM_JOY*5-1:0] joy_i;
  logic [ROWS-1:0]      row_sel_n_i;
  logic [NUM_LOCK-1:0]  lock_sel_n_i;
  logic [COLS-1:0]      col_n_o;
  logic [NUM_LOCK-1:0]  lock_o;

  ps2_key_matrix #(
    .ROWS(ROWS), .COLS(COLS), .NUM_JOY(NUM_JOY), .NUM_LOCK(NUM_LOCK), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .ps2_key_i     (ps2_key_i),
    .tick_i        (tick_i),
    .release_all_i (release_all_i),
    .joy_i         (joy_i),
    .row_sel_n_i   (row_sel_n_i),
    .lock_sel_n_i  (lock_sel_n_i),
    .col_n_o       (col_n_o),
    .lock_o        (lock_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: key table, pending-event list, per-key hold state.
  typedef struct { logic [8:0] code; bit is_lock; int row; int col; } map_t;
  typedef struct { logic [8:0] code; bit pressed; int due; } ev_t;

  map_t            key_map[$];
  ev_t             ev_q[$];
  logic [COLS-1:0] exp_q[$];
  bit              m_key  [ROWS][COLS];
  int              m_hold [ROWS][COLS];
  bit              m_pend [ROWS][COLS];
  bit              m_lock;
  int              m_cyc;

  task automatic add_map(input logic [8:0] code, input bit lk, input int r, input int c);
    map_t m;
    m.code = code; m.is_lock = lk; m.row = r; m.col = c;
    key_map.push_back(m);
  endtask

  function automatic int lookup(input logic [8:0] code);
    foreach (key_map[i]) if (key_map[i].code == code) return i;
    return -1;
  endfunction

  function automatic bit joy_on(input int r, input int c);
    for (int p = 0; p < NUM_JOY; p++)
      for (int b = 0; b < 5; b++)
        if (joy_i[p*5+b] && r == 6 + p && c == JCOL[b]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_keys();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_key[r][c] = 0; m_hold[r][c] = 0; m_pend[r][c] = 0;
      end
  endtask

  task automatic model_clear();
    clear_keys();
    m_lock = 0;
    ev_q.delete();
  endtask

  task automatic model_edge();
    logic [COLS-1:0] pull;
    ev_t ev;
    int idx;
    pull = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_sel_n_i[r] && (m_key[r][c] || joy_on(r, c))) pull[c] = 1'b1;
    if (!lock_sel_n_i[0] && m_lock) pull[LOCK_COL_B] = 1'b1;
    exp_q.push_back(~pull);
    m_cyc++;
    idx = -1;
    ev.pressed = 0;
    if (ev_q.size() > 0 && ev_q[0].due == m_cyc) begin
      ev  = ev_q.pop_front();
      idx = lookup(ev.code);
    end
`ifdef KBD_MIN_HOLD_EN
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_pend[r][c] && m_hold[r][c] == 0) begin
          m_key[r][c] = 0; m_pend[r][c] = 0;
        end
`endif
    if (idx >= 0 && !key_map[idx].is_lock) begin
`ifdef KBD_MIN_HOLD_EN
      if (ev.pressed) begin
        m_key[key_map[idx].row][key_map[idx].col]  = 1;
        m_hold[key_map[idx].row][key_map[idx].col] = HOLD_TICKS;
        m_pend[key_map[idx].row][key_map[idx].col] = 0;
      end else if (m_hold[key_map[idx].row][key_map[idx].col] == 0) begin
        m_key[key_map[idx].row][key_map[idx].col]  = 0;
      end else begin
        m_pend[key_map[idx].row][key_map[idx].col] = 1;
      end
`else
      m_key[key_map[idx].row][key_map[idx].col] = ev.pressed;
`endif
    end
`ifdef KBD_MIN_HOLD_EN
    if (tick_i)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (m_hold[r][c] > 0) m_hold[r][c]--;
`endif
    if (release_all_i) clear_keys();
    if (idx >= 0 && key_map[idx].is_lock && ev.pressed) m_lock = !m_lock;
  endtask

  task automatic step(input int n = 1);
    logic [COLS-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      if (reset_n_i) model_edge();
      else exp_q.push_back('1);
      @(negedge clk_i);
      e = exp_q.pop_front();
      check("col_n_o", col_n_o, e);
      check("lock_o", 8'(lock_o), {7'd0, m_lock});
    end
  endtask

  task automatic send_key(input logic [8:0] code, input bit pressed);
    ev_t ev;
    ps2_key_i  = {~ps2_key_i[10], pressed, code};
    ev.code    = code;
    ev.pressed = pressed;
    ev.due     = m_cyc + 2;
    ev_q.push_back(ev);
  endtask

  logic [8:0] pool [20] = '{9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h015, 9'h01D, 9'h024, 9'h02D,
                            9'h016, 9'h01E, 9'h029, 9'h05A, 9'h012, 9'h014, 9'h111, 9'h058,
                            9'h000, 9'h077, 9'h11C, 9'h01C};

  initial begin
    add_map(9'h01C, 0, 5, 2); add_map(9'h01B, 0, 1, 2); add_map(9'h023, 0, 2, 2);
    add_map(9'h02B, 0, 3, 2); add_map(9'h015, 0, 5, 3); add_map(9'h01D, 0, 1, 3);
    add_map(9'h024, 0, 2, 3); add_map(9'h02D, 0, 3, 3); add_map(9'h016, 0, 5, 4);
    add_map(9'h01E, 0, 1, 4); add_map(9'h029, 0, 1, 0); add_map(9'h05A, 0, 2, 0);
    add_map(9'h012, 0, 4, 0); add_map(9'h014, 0, 0, 1); add_map(9'h111, 0, 3, 0);
    add_map(9'h058, 1, 0, 0);

    // Clock/reset
    reset_n_i = 1'b0; ps2_key_i = '0; tick_i = 1'b0; release_all_i = 1'b0;
    joy_i = '0; row_sel_n_i = '1; lock_sel_n_i = '1;
    model_clear();
    m_cyc = 0;
    #12;
    check("rst_col", col_n_o, 8'hFF);
    check("rst_lock", 8'(lock_o), 8'h00);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(2);

    // Press 'a' and read row 5
    row_sel_n_i = 8'hDF;
    step(1);
    send_key(9'h01C, 1);
    step(2);
    check("a_before_n3", col_n_o, 8'hFF);
    step(1);
    check("a_press", col_n_o, 8'hFB);
    row_sel_n_i = 8'hFE;
    step(1);
    check("a_other_row", col_n_o, 8'hFF);
    row_sel_n_i = 8'hDF;
    step(1);

    // Release with hold time
    send_key(9'h01C, 0);
    step(3);
`ifdef KBD_MIN_HOLD_EN
    check("hold_after_release", col_n_o, 8'hFB);
    tick_i = 1; step(1); tick_i = 0; step(2);
    check("hold_tick1", col_n_o, 8'hFB);
    tick_i = 1; step(1); tick_i = 0;
    step(1);
    check("hold_last", col_n_o, 8'hFB);
    step(1);
    check("hold_drop", col_n_o, 8'hFF);
`else
    check("release_drop", col_n_o, 8'hFF);
    tick_i = 1; step(1); tick_i = 0; step(1);
    check("release_stays", col_n_o, 8'hFF);
`endif

    // Release coinciding with the tick that empties the counter
    send_key(9'h01C, 1); step(3);
    tick_i = 1; step(1); tick_i = 0;
    send_key(9'h01C, 0); step(1);
    tick_i = 1; step(1); tick_i = 0;
    step(1);
`ifdef KBD_MIN_HOLD_EN
    check("tick_release_visible", col_n_o, 8'hFB);
`endif
    step(1);
    check("tick_release_drop", col_n_o, 8'hFF);

    // Re-press while pending
    send_key(9'h01C, 1); step(3);
    send_key(9'h01C, 0); step(3);
    send_key(9'h01C, 1); step(3);
    tick_i = 1; step(1); tick_i = 0; step(1);
    tick_i = 1; step(1); tick_i = 0; step(1);
    check("repress_held", col_n_o, 8'hFB);
    send_key(9'h01C, 0); step(4);

    // Alpha lock
    row_sel_n_i = '1; lock_sel_n_i = 1'b0; step(1);
    send_key(9'h058, 1); step(2);
    check("lock_on", 8'(lock_o), 8'h01);
    step(1);
    check("lock_col", col_n_o, 8'hEF);
    send_key(9'h058, 0); step(3);
    check("lock_keep", 8'(lock_o), 8'h01);
    send_key(9'h058, 1); step(2);
    check("lock_off", 8'(lock_o), 8'h00);
    step(1);
    check("lock_col_off", col_n_o, 8'hFF);

    // Joystick
    lock_sel_n_i = '1; row_sel_n_i = 8'hBF; joy_i = 10'h010;
    step(1);
    check("joy_fire", col_n_o, 8'hFE);
    release_all_i = 1; step(1); release_all_i = 0; step(1);
    check("joy_after_clear", col_n_o, 8'hFE);
    joy_i = '0; step(1);
    check("joy_off", col_n_o, 8'hFF);

    // Reset mid-operation
    row_sel_n_i = 8'hDF; lock_sel_n_i = 1'b0;
    send_key(9'h01C, 1); step(1);
    send_key(9'h058, 1); step(3);
    check("pre_reset_col", col_n_o, 8'hEB);
    check("pre_reset_lock", 8'(lock_o), 8'h01);
    #2 reset_n_i = 1'b0;
    #1;
    check("reset_col", col_n_o, 8'hFF);
    check("reset_lock", 8'(lock_o), 8'h00);
    model_clear();
    ps2_key_i = {~ps2_key_i[10], 1'b1, 9'h01C};
    step(2);
    reset_n_i = 1'b1;
    step(3);
    check("no_ghost_event", col_n_o, 8'hFF);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      row_sel_n_i   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      lock_sel_n_i  = 1'($urandom_range(0, 1));
      tick_i        = ($urandom_range(0, 5) == 0);
      release_all_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) joy_i = 10'($urandom);
      if ($urandom_range(0, 2) == 0) send_key(pool[$urandom_range(0, 19)], 1'($urandom_range(0, 1)));
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
